// File: rtl/jtframe_ram_sched_pkg.sv
// Shared types for the RAM port-0 scheduler: FSM encoding and pipeline record.
package jtframe_ram_sched_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Index field is sized for the largest supported requester count (8).
  localparam int IDXW = 3;

  typedef struct packed {
    logic            vld;
    logic [IDXW-1:0] idx;
  } pipe_t;

endpackage

// File: rtl/jtframe_rr_arb.sv
// Round-robin picker: first eligible index at or above the pointer, wrapping.
module jtframe_rr_arb #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] elig,
  output logic [NREQ-1:0] gnt,
  output logic            vld
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic          found;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++)
      if (!found && elig[i] && PW'(i) >= ptr) begin
        found = 1'b1;
        sel   = PW'(i);
      end
    // wrap-around pass over the indices below the pointer
    for (int i = 0; i < NREQ; i++)
      if (!found && elig[i]) begin
        found = 1'b1;
        sel   = PW'(i);
      end
    vld = en && found;
    gnt = vld ? ({{(NREQ-1){1'b0}}, 1'b1} << sel) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (vld)
      ptr <= (sel == PW'(NREQ-1)) ? '0 : sel + PW'(1);
  end

endmodule

// File: rtl/jtframe_ram_sched.sv
// Shares RAM port 0 among NREQ req/ack clients, with a full clear after reset or on clr.
module jtframe_ram_sched
  import jtframe_ram_sched_pkg::*;
#(
  parameter int             DW     = 8,
  parameter int             AW     = 10,
  parameter int             NREQ   = 3,
  parameter logic [DW-1:0]  CLRVAL = {DW{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      dout,
  output logic               busy,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_data,
  output logic               ram_we,
  input  logic [DW-1:0]      ram_q
);

  state_t          state, state_nx;
  logic [AW:0]     clr_addr, clr_inc;
  logic [NREQ-1:0] pending, elig, gnt, ack_nx;
  logic            gnt_vld, arb_en;
  pipe_t           st0, st1;
  logic [IDXW-1:0] gidx;
  logic [AW-1:0]   gaddr;
  logic [DW-1:0]   gdata;
  logic            gwe;

  assign clr_inc = clr_addr + 1'b1;
  assign elig    = req & ~pending;
  assign arb_en  = (state == RUN) && !clr;

  jtframe_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .elig  (elig),
    .gnt   (gnt),
    .vld   (gnt_vld)
  );

  always_comb begin
    gidx  = '0;
    gaddr = '0;
    gdata = '0;
    gwe   = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        gidx  = IDXW'(i);
        gaddr = addr[i*AW +: AW];
        gdata = din[i*DW +: DW];
        gwe   = we[i];
      end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      ack_nx[i] = st1.vld && (st1.idx == IDXW'(i));
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_inc[AW]) state_nx = RUN;
      RUN:     if (clr) state_nx = DRAIN;
      DRAIN:   if (!st0.vld && !st1.vld) state_nx = CLEAR;
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      pending  <= '0;
      st0      <= '0;
      st1      <= '0;
      ack      <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
    end else begin
      state   <= state_nx;
      // covers the whole clear including its final write cycle
      busy    <= (state != RUN) || (state_nx != RUN);
      st0.vld <= gnt_vld;
      st0.idx <= gidx;
      st1     <= st0;
      pending <= (pending | gnt) & ~ack_nx;
      ack     <= ack_nx;
      if (st1.vld) dout <= ram_q;
      case (state)
        CLEAR: begin
          ram_we   <= 1'b1;
          ram_addr <= clr_addr[AW-1:0];
          ram_data <= CLRVAL;
          clr_addr <= clr_inc;
        end
        DRAIN: begin
          ram_we   <= 1'b0;
          clr_addr <= '0;
        end
        default: begin
          ram_we <= gnt_vld && gwe;
          if (gnt_vld) begin
            ram_addr <= gaddr;
            ram_data <= gdata;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_ram_sched.sv
// Directed bench for jtframe_ram_sched with a behavioural port-0 RAM and ack scoreboard.
module tb_jtframe_ram_sched;

  localparam int DW = 8, AW = 4, NREQ = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic [NREQ-1:0]    req = '0, we = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] din = '0;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      dout, ram_data, ram_q;
  logic               busy, ram_we;
  logic [AW-1:0]      ram_addr;

  jtframe_ram_sched #(.DW(DW), .AW(AW), .NREQ(NREQ), .CLRVAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .we(we), .addr(addr), .din(din),
    .ack(ack), .dout(dout), .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // port-0 RAM: read-before-write, registered q
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int a = 0; a < (1<<AW); a++) mem[a] = 8'hC0 + 8'(a);
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  typedef struct { int idx; int d; int cyc; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  task automatic push(input int idx, input int d, input int c);
    exp_t e;
    e.idx = idx; e.d = d; e.cyc = c;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && ack != '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", int'(ack), 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("ack_idx", int'(ack), 1 << mon_e.idx);
        chk("dout", int'(dout), mon_e.d);
        if (mon_e.cyc >= 0) chk("ack_cycle", cyc, mon_e.cyc);
      end
    end
  end

  int plan_n[NREQ];
  int plan_addr[NREQ][2];
  int plan_d[NREQ];
  bit plan_we[NREQ];

  task automatic run_plan();
    int k[NREQ];
    int t;
    for (int i = 0; i < NREQ; i++) begin
      k[i] = 0;
      if (plan_n[i] > 0) begin
        req[i] = 1'b1;
        we[i]  = plan_we[i];
        addr[i*AW +: AW] = AW'(plan_addr[i][0]);
        din[i*DW +: DW]  = DW'(plan_d[i]);
      end
    end
    t = 0;
    while (req != '0 && t < 60) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < NREQ; i++)
        if (req[i] && ack[i]) begin
          k[i]++;
          if (k[i] >= plan_n[i]) req[i] = 1'b0;
          else addr[i*AW +: AW] = AW'(plan_addr[i][k[i]]);
        end
    end
    if (req != '0) begin
      chk("plan_timeout", int'(req), 0);
      req = '0;
    end
    for (int i = 0; i < NREQ; i++) plan_n[i] = 0;
  endtask

  task automatic single(input int i, input bit w, input int a, input int d, input int exp_d);
    plan_n[i] = 1; plan_we[i] = w; plan_addr[i][0] = a; plan_d[i] = d;
    push(i, exp_d, cyc + 3);
    run_plan();
  endtask

  task automatic check_clear(input int exp_start);
    int n, start, t;
    t = 0;
    while (!ram_we && t < 20) begin @(negedge clk); t++; end
    chk("clear_started", int'(ram_we), 1);
    start = cyc;
    n = 0;
    while (ram_we && n < 40) begin
      chk("clear_addr", int'(ram_addr), n);
      chk("clear_data", int'(ram_data), 0);
      chk("clear_busy", int'(busy), 1);
      chk("clear_ack", int'(ack), 0);
      n++;
      @(negedge clk);
    end
    chk("clear_len", n, 1 << AW);
    chk("busy_after_clear", int'(busy), 0);
    if (exp_start >= 0) chk("clear_start_cycle", start, exp_start);
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < (1<<AW); a++) single(a % NREQ, 1'b0, a, 0, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ack", int'(ack), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_data", int'(ram_data), 0);
  endtask

  int c0, t;

  initial begin
    for (int i = 0; i < NREQ; i++) plan_n[i] = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    check_clear(-1);
    read_all_zero();

    // write then read back: old value first, new value second
    single(1, 1'b1, 3, 8'hA5, 8'h00);
    single(1, 1'b0, 3, 0, 8'hA5);

    // preload 4..9 with 0x10+addr; last writer is requester 2
    for (int a = 4; a <= 9; a++) single((a - 4) % NREQ, 1'b1, a, 8'h10 + a, 8'h00);

    // all three held, two reads each: order 0,1,2,0,1,2 one per cycle
    c0 = cyc;
    for (int i = 0; i < NREQ; i++) begin
      plan_n[i] = 2; plan_we[i] = 1'b0; plan_addr[i][0] = 4 + i; plan_addr[i][1] = 7 + i;
      plan_d[i] = 0;
    end
    push(0, 8'h14, c0 + 3); push(1, 8'h15, c0 + 4); push(2, 8'h16, c0 + 5);
    push(0, 8'h17, c0 + 6); push(1, 8'h18, c0 + 7); push(2, 8'h19, c0 + 8);
    run_plan();

    // pointer to 1, then 0 and 2 together: 2 wins first
    single(0, 1'b0, 3, 0, 8'hA5);
    c0 = cyc;
    plan_n[0] = 1; plan_we[0] = 1'b0; plan_addr[0][0] = 4; plan_d[0] = 0;
    plan_n[2] = 1; plan_we[2] = 1'b0; plan_addr[2][0] = 6; plan_d[2] = 0;
    push(2, 8'h16, c0 + 3); push(0, 8'h14, c0 + 4);
    run_plan();

    // clr with two reads in flight
    c0 = cyc;
    plan_n[0] = 1; plan_we[0] = 1'b0; plan_addr[0][0] = 4; plan_d[0] = 0;
    plan_n[1] = 1; plan_we[1] = 1'b0; plan_addr[1][0] = 5; plan_d[1] = 0;
    push(1, 8'h15, c0 + 3); push(0, 8'h14, c0 + 4);
    fork
      run_plan();
      begin
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("busy_after_clr", int'(busy), 1);
      end
    join
    check_clear(c0 + 6);
    read_all_zero();

    // reset in the middle of a clear at address 7
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    t = 0;
    while (!(ram_we && ram_addr == AW'(7)) && t < 40) begin @(negedge clk); t++; end
    chk("reached_addr7", int'(ram_addr), 7);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    check_clear(-1);

    // reset with a read in flight: no ack ever appears for it
    req[0] = 1'b1; we[0] = 1'b0; addr[0 +: AW] = AW'(2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    check_clear(-1);
    single(1, 1'b0, 3, 0, 8'h00);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d errors", n_chk, n_err);
    $fatal(1);
  end

endmodule
